// File: rtl/cargador_de_instrucciones_if.sv
// Loader bus: start command, byte stream handshake and instruction-memory write port.
interface cargador_de_instrucciones_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  i_start;
    logic [15:0]           i_word_count;
    logic [7:0]            i_byte;
    logic                  i_byte_valid;
    logic                  o_byte_ready;
    logic                  o_write_enable;
    logic [ADDR_WIDTH-1:0] o_address;
    logic [7:0]            o_data;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_error;
    logic                  o_fetch_hold;

    // Host / stream source side
    modport master (
        output i_start, i_word_count, i_byte, i_byte_valid,
        input  o_byte_ready, o_write_enable, o_address, o_data,
               o_busy, o_done, o_error, o_fetch_hold
    );

    // Loader side
    modport slave (
        input  i_start, i_word_count, i_byte, i_byte_valid,
        output o_byte_ready, o_write_enable, o_address, o_data,
               o_busy, o_done, o_error, o_fetch_hold
    );
endinterface

// File: rtl/cargador_de_instrucciones.sv
// Program loader: turns a byte stream into consecutive byte writes of the
// instruction memory and holds the fetch stage until the program is complete.
module cargador_de_instrucciones #(
    parameter int unsigned MEM_BYTES  = 256,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    cargador_de_instrucciones_if.slave   bus
);
    localparam int unsigned CNT_W = 18;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_remaining;
    logic [ADDR_WIDTH-1:0] r_addr;

    logic                  r_write_enable;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [7:0]            r_data;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic                  r_fetch_hold;

    logic [CNT_W-1:0]      w_bytes;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_load_start;

    assign w_bytes = {bus.i_word_count, 2'b00};

    // Next-state decode, stream acceptance and load-start qualification
    always_comb begin
        w_next       = r_state;
        w_ready      = 1'b0;
        w_accept     = 1'b0;
        w_load_start = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.i_start) begin
                    if (w_bytes == '0) begin
                        w_next = S_DONE;
                    end else if (w_bytes > CNT_W'(MEM_BYTES)) begin
                        w_next = S_ERROR;
                    end else begin
                        w_next       = S_LOAD;
                        w_load_start = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                w_ready  = 1'b1;
                w_accept = bus.i_byte_valid;
                if (w_accept && (r_remaining == CNT_W'(1))) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_next = S_DONE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Byte counter, write pointer and memory write port
    always_ff @(posedge clk) begin
        if (reset) begin
            r_remaining    <= '0;
            r_addr         <= '0;
            r_write_enable <= 1'b0;
            r_address      <= '0;
            r_data         <= '0;
        end else begin
            r_write_enable <= w_accept;
            if (w_load_start) begin
                r_remaining <= w_bytes;
                r_addr      <= '0;
            end else if (w_accept) begin
                r_address   <= r_addr;
                r_data      <= bus.i_byte;
                r_addr      <= r_addr + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - CNT_W'(1);
            end
        end
    end

    // Status flags registered from the next state so they track the state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_fetch_hold <= 1'b1;
        end else begin
            r_busy       <= (w_next == S_LOAD) || (w_next == S_FLUSH);
            r_done       <= (w_next == S_DONE);
            r_error      <= (w_next == S_ERROR);
            r_fetch_hold <= (w_next != S_DONE);
        end
    end

    assign bus.o_byte_ready   = w_ready;
    assign bus.o_write_enable = r_write_enable;
    assign bus.o_address      = r_address;
    assign bus.o_data         = r_data;
    assign bus.o_busy         = r_busy;
    assign bus.o_done         = r_done;
    assign bus.o_error        = r_error;
    assign bus.o_fetch_hold   = r_fetch_hold;
endmodule
